if_id_buffer: RTL and testbench
===============================

IF_ID_BUFFER -- requirements
Module: if_id_buffer

Interface
REQ-001 Parameter DATA_W, default 32: instruction width in bits.
REQ-002 Parameter PC_W, default 32: width of the PC+4 value in bits.
REQ-003 Parameter DEPTH, default 4: entry count; power of two, at least 2.
REQ-004 Parameter NOP_INSTR, default 32'h0000_0000: instruction presented when the buffer is empty; DATA_W bits wide.
REQ-005 clk  input  1: single clock; all state updates on the rising edge.
REQ-006 reset  input  1: synchronous, active-high reset.
REQ-007 flush  input  1: discard all buffered entries (branch or jump redirect).
REQ-008 in_valid  input  1: fetch stage presents a word.
REQ-009 in_ready  output  1: buffer can accept a word this cycle.
REQ-010 in_instr  input  DATA_W: fetched instruction.
REQ-011 in_pc_plus4  input  PC_W: PC+4 of the fetched instruction.
REQ-012 out_valid  output  1: head entry is valid.
REQ-013 out_ready  input  1: decode accepts the head entry; low means hazard stall.
REQ-014 out_instr  output  DATA_W: head instruction, or NOP_INSTR when empty.
REQ-015 out_pc_plus4  output  PC_W: head PC+4, or 0 when empty.
REQ-016 count  output  $clog2(DEPTH+1): number of occupied entries.

Function
REQ-017 Push SHALL occur when in_valid && in_ready && !flush; the entry is written at the tail and the tail pointer advances modulo DEPTH.
REQ-018 Pop SHALL occur when out_valid && out_ready && !flush; the head pointer advances modulo DEPTH.
REQ-019 in_ready SHALL equal (count != DEPTH), driven combinationally from registered state only, with no dependence on out_ready (no pass-through when full).
REQ-020 out_valid SHALL equal (count != 0).
REQ-021 out_instr and out_pc_plus4 SHALL come from the head entry when out_valid=1, and SHALL be NOP_INSTR and 0 when out_valid=0; outputs are never X or Z after reset.
REQ-022 Latency: a word pushed in cycle N SHALL appear at the output in cycle N+1 at the earliest; there is no combinational in-to-out bypass.
REQ-023 count update:
- push only: +1
- pop only: -1
- push and pop together: unchanged
- neither: unchanged
REQ-024 Simultaneous push and pop with 0 < count < DEPTH SHALL keep count unchanged and advance both pointers.
REQ-025 Full (count=DEPTH): in_ready=0; a pop in that cycle SHALL reduce count to DEPTH-1, and in_ready SHALL rise the following cycle.
REQ-026 Empty (count=0): out_ready SHALL have no effect, and no pop occurs.
REQ-027 flush=1 SHALL, on the next edge, set count=0, head=tail=0, and out_valid=0, and SHALL discard any same-cycle push and pop; flush has priority over push and pop.
REQ-028 flush with in_valid held high: the word presented in the flush cycle is dropped, and the word presented in the next cycle is accepted normally.
REQ-029 Pointers SHALL wrap from DEPTH-1 to 0 without loss or duplication of entries.
REQ-030 Stored entries SHALL hold their value while out_ready=0 for any number of cycles.

Reset
REQ-031 reset=1 at a rising edge SHALL set count=0, head=tail=0, out_valid=0, out_instr=NOP_INSTR, out_pc_plus4=0, and in_ready=1 after the edge.
REQ-032 reset SHALL take priority over flush, push and pop; reset asserted mid-operation discards all entries.
REQ-033 Storage array contents need not be cleared by reset and SHALL never be visible while out_valid=0.

Verification
REQ-034 Reset, then push 0x11,0x22,0x33 (pc 4,8,12) with out_ready=1 -> outputs appear in order one cycle after each push; count never exceeds 1.
REQ-035 out_ready=0, then push 5 words with DEPTH=4 -> count=4, in_ready=0; the 5th word is not accepted; out_instr holds the first word throughout.
REQ-036 Full buffer, in_valid=1 and out_ready=1 for one cycle -> count=3 and no push that cycle; next cycle push and pop together keep count=3.
REQ-037 count=3 plus flush with in_valid=1 and in_instr=0xAA -> next cycle count=0, out_instr=NOP_INSTR; 0xAA is never output.
REQ-038 Stream 10 words through DEPTH=4 with out_ready toggling 1,0,1,0 -> pointers wrap; output order equals input order with no duplicates.
REQ-039 Assert reset with count=2 and simultaneous flush and push -> count=0, in_ready=1, out_pc_plus4=0 on the next cycle.

Source files
------------

// File: rtl/if_id_buffer.sv
// IF/ID decoupling FIFO between fetch and decode.
// Registered head output; NOP shown when empty, flush drops all entries.
module if_id_buffer #(
  parameter int unsigned            DATA_W    = 32,
  parameter int unsigned            PC_W      = 32,
  parameter int unsigned            DEPTH     = 4,
  parameter logic [DATA_W-1:0]      NOP_INSTR = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             in_instr,
  input  logic [PC_W-1:0]               in_pc_plus4,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             out_instr,
  output logic [PC_W-1:0]               out_pc_plus4,
  output logic [$clog2(DEPTH+1)-1:0]    count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DATA_W-1:0] r_instr [DEPTH];
  logic [PC_W-1:0]   r_pc    [DEPTH];
  logic [AW-1:0]     r_head;
  logic [AW-1:0]     r_tail;
  logic [CW-1:0]     r_count;

  logic w_push;
  logic w_pop;

  assign in_ready  = (r_count != FULL);
  assign out_valid = (r_count != '0);
  assign count     = r_count;

  assign w_push = in_valid && in_ready && !flush;
  assign w_pop  = out_valid && out_ready && !flush;

  // storage is never exposed while empty, so it needs no reset
  assign out_instr    = out_valid ? r_instr[r_head] : NOP_INSTR;
  assign out_pc_plus4 = out_valid ? r_pc[r_head]    : '0;

  always_ff @(posedge clk) begin
    if (w_push && !reset) begin
      r_instr[r_tail] <= in_instr;
      r_pc[r_tail]    <= in_pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + AW'(1);
      if (w_pop)  r_head <= r_head + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed self-checking bench for if_id_buffer.
// Inputs change 1ns after each rising edge; outputs sampled there.
module tb_if_id_buffer;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready;
  logic [31:0] in_instr, in_pc_plus4;
  logic        out_valid, out_ready;
  logic [31:0] out_instr, out_pc_plus4;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  if_id_buffer #(.DATA_W(32), .PC_W(32), .DEPTH(4), .NOP_INSTR(32'h0)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc_plus4(in_pc_plus4),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc_plus4(out_pc_plus4),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins,
                       input logic [31:0] pc);
    in_valid    = v;
    in_instr    = ins;
    in_pc_plus4 = pc;
  endtask

  initial begin
    logic [31:0] q[$];
    int          sent;
    int          got;
    int          mcnt;
    bit          p_push, p_pop;

    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    tick();
    tick();
    reset = 1'b0;
    chk("rst_count", count, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_out_pc", out_pc_plus4, 0);

    // in-order flow-through, one-cycle latency
    out_ready = 1'b1;
    drive(1'b1, 32'h11, 32'd4);
    chk("lat_no_bypass", out_valid, 0);
    tick();
    chk("ft1_instr", out_instr, 32'h11);
    chk("ft1_pc", out_pc_plus4, 4);
    chk("ft1_count", count, 1);
    drive(1'b1, 32'h22, 32'd8);
    tick();
    chk("ft2_instr", out_instr, 32'h22);
    chk("ft2_pc", out_pc_plus4, 8);
    chk("ft2_count", count, 1);
    drive(1'b1, 32'h33, 32'd12);
    tick();
    chk("ft3_instr", out_instr, 32'h33);
    chk("ft3_pc", out_pc_plus4, 12);
    chk("ft3_count", count, 1);
    drive(1'b0, 32'h0, 32'h0);
    tick();
    chk("ft_drain_count", count, 0);
    chk("ft_drain_nop", out_instr, 0);
    chk("ft_drain_pc", out_pc_plus4, 0);

    // stall and fill to full
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'hA1 + i, 32'h100 + 4 * i);
      tick();
      chk("fill_count", count, (i < 4) ? i + 1 : 4);
      chk("fill_head", out_instr, 32'hA1);
      chk("fill_head_pc", out_pc_plus4, 32'h100);
    end
    chk("full_in_ready", in_ready, 0);

    // pop from full: no push that cycle
    out_ready = 1'b1;
    tick();
    chk("popfull_count", count, 3);
    chk("popfull_head", out_instr, 32'hA2);
    chk("popfull_in_ready", in_ready, 1);
    drive(1'b1, 32'hA6, 32'h200);
    tick();
    chk("pushpop_count", count, 3);
    chk("pushpop_head", out_instr, 32'hA3);

    // flush drops same-cycle push
    flush = 1'b1;
    drive(1'b1, 32'hAA, 32'h300);
    tick();
    flush = 1'b0;
    chk("flush_count", count, 0);
    chk("flush_valid", out_valid, 0);
    chk("flush_nop", out_instr, 0);
    chk("flush_pc", out_pc_plus4, 0);
    out_ready = 1'b0;
    drive(1'b1, 32'hBB, 32'h304);
    tick();
    chk("post_flush_count", count, 1);
    chk("post_flush_instr", out_instr, 32'hBB);
    drive(1'b0, 32'h0, 32'h0);
    out_ready = 1'b1;
    tick();
    chk("post_flush_drain", count, 0);

    // stream 10 words with toggling out_ready, checked against a queue
    sent = 0; got = 0; mcnt = 0;
    for (int cyc = 0; cyc < 60 && got < 10; cyc++) begin
      out_ready = (cyc % 2) == 0;
      if (sent < 10) drive(1'b1, 32'hC0 + sent, 32'h400 + 4 * sent);
      else drive(1'b0, 32'h0, 32'h0);
      chk("strm_in_ready", in_ready, (mcnt != 4));
      p_push = (sent < 10) && (mcnt != 4);
      p_pop  = out_ready && (mcnt != 0);
      if (p_pop) begin
        chk("strm_order", out_instr, 32'hC0 + got);
        chk("strm_pc", out_pc_plus4, 32'h400 + 4 * got);
        got++;
        void'(q.pop_front());
      end
      if (p_push) begin
        q.push_back(32'hC0 + sent);
        sent++;
      end
      mcnt = q.size();
      tick();
      chk("strm_count", count, mcnt);
      if (mcnt != 0) chk("strm_head", out_instr, q[0]);
    end
    chk("strm_all_out", got, 10);
    drive(1'b0, 32'h0, 32'h0);

    // reset wins over flush and push mid-operation
    out_ready = 1'b0;
    drive(1'b1, 32'hD1, 32'h500);
    tick();
    drive(1'b1, 32'hD2, 32'h504);
    tick();
    chk("pre_rst_count", count, 2);
    reset = 1'b1; flush = 1'b1;
    drive(1'b1, 32'hD3, 32'h508);
    tick();
    reset = 1'b0; flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    chk("midrst_count", count, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_pc", out_pc_plus4, 0);
    chk("midrst_valid", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
